// File: rtl/score_digit_driver.sv
// Binary score to BCD (sequential double-dabble) with a 4-digit multiplexed
// common-anode 7-segment driver, optional leading-zero blanking and saturation.
module score_digit_driver #(
   parameter int CLK_HZ   = 100_000_000,
   parameter int SCAN_HZ  = 1_000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] score,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        ovf
);

   localparam int PRESC_MAX = (CLK_HZ / SCAN_HZ > 1) ? (CLK_HZ / SCAN_HZ) - 1 : 0;
   localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_MAX);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_SHIFT  = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   logic [1:0]    r_state;
   logic [15:0]   r_last;
   logic [15:0]   r_bin;
   logic [19:0]   r_bcd;
   logic [4:0]    r_cnt;
   logic [15:0]   r_digits;
   logic          r_ovf;
   logic [PW-1:0] r_presc;
   logic [1:0]    r_idx;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;

   logic [19:0]   w_bcd_adj;
   logic [35:0]   w_shift;
   logic [3:0]    w_blank;
   logic [3:0]    w_digit;

   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h40;
         4'd1:    p = 7'h79;
         4'd2:    p = 7'h24;
         4'd3:    p = 7'h30;
         4'd4:    p = 7'h19;
         4'd5:    p = 7'h12;
         4'd6:    p = 7'h02;
         4'd7:    p = 7'h78;
         4'd8:    p = 7'h00;
         4'd9:    p = 7'h10;
         default: p = 7'h7F;
      endcase
      return p;
   endfunction

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_adj
         assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                       r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
      end
   endgenerate

   assign w_shift = {w_bcd_adj[18:0], r_bin, 1'b0};

   assign w_blank[0] = 1'b0;
   generate
      for (gi = 1; gi < 4; gi++) begin : g_blank
         assign w_blank[gi] = BLANK_LZ && ~|r_digits[15:gi*4];
      end
   endgenerate

   assign w_digit = r_digits[{r_idx, 2'b00} +: 4];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_last   <= '0;
         r_bin    <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_digits <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (score != r_last) begin
                  r_last  <= score;
                  r_bin   <= score;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_bcd   <= '0;
               r_cnt   <= 5'd16;
               r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               {r_bcd, r_bin} <= w_shift;
               r_cnt          <= r_cnt - 5'd1;
               if (r_cnt == 5'd1)
                  r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               // Anything past four digits saturates the display at 9999.
               if (|r_bcd[19:16]) begin
                  r_digits <= 16'h9999;
                  r_ovf    <= 1'b1;
               end else begin
                  r_digits <= r_bcd[15:0];
                  r_ovf    <= 1'b0;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_seg   <= 7'h7F;
         r_an    <= 4'hF;
      end else begin
         if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
         r_an  <= ~(4'b0001 << r_idx);
         r_seg <= w_blank[r_idx] ? 7'h7F : seg_pattern(w_digit);
      end
   end

   assign seg = r_seg;
   assign an  = r_an;
   assign ovf = r_ovf;

endmodule
